// File: rtl/l1_cache_pkg.sv
// Shared geometry, line metadata type and address-field helpers for the L1 data cache.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package l1_cache_pkg;

    localparam int ADDR_BITS      = 32;
    localparam int WORD_W         = 32;
    localparam int SETS           = 128;
    localparam int OFFSET_BITS    = 4;
    localparam int INDEX_BITS     = 7;
    localparam int TAG_BITS       = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_BITS      = 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
    } line_meta_t;

    function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDR_BITS-1:0] addr);
        return addr[OFFSET_BITS +: INDEX_BITS];
    endfunction

    function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDR_BITS-1:0] addr);
        return addr[ADDR_BITS-1 -: TAG_BITS];
    endfunction

    // Word select within a line; byte offset bits [1:0] are ignored (word-aligned accesses).
    function automatic logic [WORD_BITS-1:0] get_word(input logic [ADDR_BITS-1:0] addr);
        return addr[2 +: WORD_BITS];
    endfunction

endpackage

// File: rtl/l1_cache_way.sv
// One cache way: valid/tag/data arrays, combinational lookup and fill-index metadata reads.
// Latency: reads combinational; all array writes land at the next posedge.
// Backpressure: none; every write request is accepted in the cycle it is presented.
//
// Ports: clk/rst (sync, active-high; only valid bits reset), lookup port (lk_*),
// fill-index metadata port (fl_*), CPU word write (cpu_*), fill word write (fill_*),
// valid clear / tag+valid commit at fl_index (valid_clr, meta_set, meta_tag).
module l1_cache_way
    import l1_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] lk_index,
    input  logic [WORD_BITS-1:0]  lk_word,
    output line_meta_t            lk_meta,
    output logic [DATA_WIDTH-1:0] lk_data,
    input  logic [INDEX_BITS-1:0] fl_index,
    output line_meta_t            fl_meta,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic                  fill_we,
    input  logic [WORD_BITS-1:0]  fill_word,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  valid_clr,
    input  logic                  meta_set,
    input  logic [TAG_BITS-1:0]   meta_tag
);

    logic [SETS-1:0]       valid_q;
    logic [TAG_BITS-1:0]   tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

    assign lk_meta = '{valid: valid_q[lk_index], tag: tag_q[lk_index]};
    assign lk_data = data_q[lk_index][lk_word];
    assign fl_meta = '{valid: valid_q[fl_index], tag: tag_q[fl_index]};

    // A single-word fill would clear and commit in the same cycle; commit wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (valid_clr) valid_q[fl_index] <= 1'b0;
            if (meta_set)  valid_q[fl_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_set) tag_q[fl_index] <= meta_tag;
    end

    // Fill write is issued last so it overrides a CPU write to the same word.
    always_ff @(posedge clk) begin
        if (cpu_we)  data_q[lk_index][lk_word] <= cpu_data;
        if (fill_we) data_q[fl_index][fill_word] <= fill_data;
    end

endmodule

// File: rtl/l1_dcache.sv
// Two-way set-associative write-through L1 data cache with MMU-driven word refills.
// Latency: hit/read data combinational (0 cycles); writes, fills and commits visible after next posedge.
// Backpressure: none; CPU accesses and fill words are consumed every cycle they are valid.
//
// Ports: clk, rst (sync, active-high); CPU port mem_valid/mem_we/mem_addr/mem_w_data ->
// mem_r_data/cache_hit; fill port fill_en/fill_addr/fill_data/fill_mark_valid from the MMU.
// Build option: define L1_LRU_EN for true LRU replacement; default is round-robin on commit.
module l1_dcache
    import l1_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 4096,
    parameter int LINE_SIZE  = 16,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [DATA_WIDTH-1:0] mem_r_data,
    output logic                  cache_hit,
    input  logic                  fill_en,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  fill_mark_valid
);

    // The package geometry is fixed; reject any other parameterisation at elaboration.
    localparam bit GEOM_OK = (CACHE_SIZE / (LINE_SIZE * WAYS) == SETS) && (WAYS == 2) &&
                             (DATA_WIDTH == WORD_W) && (ADDR_WIDTH == ADDR_BITS) &&
                             (LINE_SIZE == WORDS_PER_LINE * 4);
    if (!GEOM_OK) begin : g_bad_geom
        $error("l1_dcache: unsupported geometry");
    end

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] fl_idx;

    line_meta_t            lk_meta [2];
    line_meta_t            fl_meta [2];
    logic [DATA_WIDTH-1:0] lk_data [2];

    logic [1:0] way_hit;
    logic       hit_way;
    logic       fill_go;
    logic       fill_start;
    logic       commit;
    logic       victim_new;
    logic       fill_way;

    logic            fill_active_q;
    logic            victim_q;
    logic [SETS-1:0] repl_q;

    assign lk_idx = get_index(mem_addr);
    assign lk_tag = get_tag(mem_addr);
    assign fl_idx = get_index(fill_addr);

    // Outputs are forced quiet while rst is high, before the valid bits have cleared.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_hit[w] = mem_valid & ~rst & lk_meta[w].valid & (lk_meta[w].tag == lk_tag);
        end
    end

    assign cache_hit  = |way_hit;
    assign hit_way    = ~way_hit[0];
    assign mem_r_data = way_hit[0] ? lk_data[0] :
                        way_hit[1] ? lk_data[1] : '0;

    // Victim choice: prefer an empty way, otherwise follow the set's replacement bit.
    assign victim_new = ~fl_meta[0].valid ? 1'b0 :
                        ~fl_meta[1].valid ? 1'b1 : repl_q[fl_idx];

    assign fill_go    = fill_en & ~rst;
    assign fill_start = fill_go & ~fill_active_q;
    assign commit     = fill_go & fill_mark_valid;
    // The first fill word is written before the victim latch has loaded.
    assign fill_way   = fill_active_q ? victim_q : victim_new;

    for (genvar w = 0; w < 2; w++) begin : g_way
        l1_cache_way #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .lk_index  (lk_idx),
            .lk_word   (get_word(mem_addr)),
            .lk_meta   (lk_meta[w]),
            .lk_data   (lk_data[w]),
            .fl_index  (fl_idx),
            .fl_meta   (fl_meta[w]),
            .cpu_we    (way_hit[w] & mem_we),
            .cpu_data  (mem_w_data),
            .fill_we   (fill_go & (fill_way == 1'(w))),
            .fill_word (get_word(fill_addr)),
            .fill_data (fill_data),
            .valid_clr (fill_start & (victim_new == 1'(w))),
            .meta_set  (commit & (fill_way == 1'(w))),
            .meta_tag  (get_tag(fill_addr))
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_active_q <= 1'b0;
            victim_q      <= 1'b0;
            repl_q        <= '0;
        end else begin
            if (fill_start) victim_q <= victim_new;

            if (commit)          fill_active_q <= 1'b0;
            else if (fill_start) fill_active_q <= 1'b1;

`ifdef L1_LRU_EN
            // Point at the way not most recently touched; a commit in the same
            // cycle is the later event for its set.
            if (cache_hit) repl_q[lk_idx] <= ~hit_way;
            if (commit)    repl_q[fl_idx] <= ~fill_way;
`else
            if (commit)    repl_q[fl_idx] <= ~repl_q[fl_idx];
`endif
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: scripted CPU/fill cycles with an expected-result queue.
// Latency: expectations are checked in the same cycle as the access (combinational hit path).
// Backpressure: n/a; the bench drives one access per cycle.
module tb_l1_dcache;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;
    logic        cache_hit;
    logic        fill_en;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        fill_mark_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    l1_dcache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_w_data      (mem_w_data),
        .mem_r_data      (mem_r_data),
        .cache_hit       (cache_hit),
        .fill_en         (fill_en),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .fill_mark_valid (fill_mark_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive CPU and fill inputs, optionally queue an expectation,
    // compare at the falling edge, then step past the next rising edge.
    task automatic cycle(input string tag,
                         input logic cv, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwdata, input logic chk,
                         input logic exp_hit, input logic [31:0] exp_data,
                         input logic fen, input logic [31:0] faddr,
                         input logic [31:0] fdata, input logic fmark);
        logic [32:0] e;
        string       t;
        mem_valid       = cv;
        mem_we          = cwe;
        mem_addr        = caddr;
        mem_w_data      = cwdata;
        fill_en         = fen;
        fill_addr       = faddr;
        fill_data       = fdata;
        fill_mark_valid = fmark;
        if (chk) begin
            exp_q.push_back({exp_hit, exp_data});
            tag_q.push_back(tag);
        end
        @(negedge clk);
        if (chk) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".hit"}, {31'b0, cache_hit}, {31'b0, e[32]});
            check({t, ".data"}, mem_r_data, e[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic h, input logic [31:0] d);
        cycle(tag, 1'b1, 1'b0, a, 32'h0, 1'b1, h, d, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic h, input logic [31:0] d);
        cycle(tag, 1'b1, 1'b1, a, wd, 1'b1, h, d, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic fill_word(input logic [31:0] a, input logic [31:0] d, input logic m);
        cycle("", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, a, d, m);
    endtask

    task automatic fill_line(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
        fill_word(base,        d0, 1'b0);
        fill_word(base + 32'h4, d1, 1'b0);
        fill_word(base + 32'h8, d2, 1'b0);
        fill_word(base + 32'hC, d3, 1'b1);
    endtask

    logic [31:0] vic_addr;

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_w_data = '0;
        fill_en = 1'b0; fill_addr = '0; fill_data = '0; fill_mark_valid = 1'b0;
        @(posedge clk);
        #1;
        rd("reset_rd", 32'h100, 1'b0, 32'h0);
        rst = 1'b0;

        // Cold miss, then a refill with a lookup into the line mid-fill.
        rd("cold_rd", 32'h100, 1'b0, 32'h0);
        fill_word(32'h100, 32'h11, 1'b0);
        cycle("mid_fill_rd", 1'b1, 1'b0, 32'h10C, 32'h0, 1'b1, 1'b0, 32'h0,
              1'b1, 32'h104, 32'h22, 1'b0);
        fill_word(32'h108, 32'h33, 1'b0);
        fill_word(32'h10C, 32'h44, 1'b1);
        rd("post_fill_108", 32'h108, 1'b1, 32'h33);
        rd("post_fill_100", 32'h100, 1'b1, 32'h11);

        // Write hit returns the old word this cycle, new word afterwards; write miss allocates nothing.
        wr("wr_hit", 32'h104, 32'hDEAD_BEEF, 1'b1, 32'h22);
        rd("rd_after_wr", 32'h104, 1'b1, 32'hDEAD_BEEF);
        wr("wr_miss", 32'h900, 32'h1234_5678, 1'b0, 32'h0);
        rd("rd_after_wr_miss", 32'h900, 1'b0, 32'h0);

        // Three tags on index 0x10 with a touch of 0x100 before the third fill.
        fill_line(32'h900, 32'h91, 32'h92, 32'h93, 32'h94);
        rd("second_way_900", 32'h900, 1'b1, 32'h91);
        rd("touch_100", 32'h100, 1'b1, 32'h11);
        fill_line(32'h1100, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
`ifdef L1_LRU_EN
        rd("lru_keep_100", 32'h100, 1'b1, 32'h11);
        rd("lru_evict_900", 32'h900, 1'b0, 32'h0);
        vic_addr = 32'h100;
`else
        rd("rr_evict_100", 32'h100, 1'b0, 32'h0);
        rd("rr_keep_900", 32'h90C, 1'b1, 32'h94);
        vic_addr = 32'h900;
`endif
        rd("third_1100", 32'h1100, 1'b1, 32'hA1);

        // Fill word and CPU write hit to the same array word in the fill's first cycle.
        cycle("coll", 1'b1, 1'b1, vic_addr, 32'hBAD0_0000, 1'b0, 1'b0, 32'h0,
              1'b1, 32'h1900, 32'hF1, 1'b0);
        fill_word(32'h1904, 32'hF2, 1'b0);
        fill_word(32'h1908, 32'hF3, 1'b0);
        fill_word(32'h190C, 32'hF4, 1'b1);
        rd("coll_fill_wins", 32'h1900, 1'b1, 32'hF1);
        rd("coll_last_word", 32'h190C, 1'b1, 32'hF4);
        rd("coll_victim_gone", vic_addr, 1'b0, 32'h0);
        rd("coll_other_way", 32'h1104, 1'b1, 32'hA2);

        // Reset in the middle of a refill.
        fill_word(32'h200, 32'hB1, 1'b0);
        fill_word(32'h204, 32'hB2, 1'b0);
        rst = 1'b1;
        rd("rst_gated_out", 32'h1100, 1'b0, 32'h0);
        rst = 1'b0;
        rd("rst_abandon_200", 32'h200, 1'b0, 32'h0);
        rd("rst_cleared_1100", 32'h1100, 1'b0, 32'h0);
        fill_line(32'h200, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        rd("refill_20C", 32'h20C, 1'b1, 32'hB4);
        rd("refill_200", 32'h200, 1'b1, 32'hB1);

        mem_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Two-way set-associative, write-through L1 data cache sitting between the CPU memory port and the MMU's miss-handling FSM. It provides combinational hit detection and read data. It updates resident words on CPU write hits. Line refills arrive one word per cycle through a dedicated fill port driven by the MMU from main RAM. The cache never talks to RAM itself; RAM writes and refill sequencing are handled by the MMU.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; 32 only.
- ADDR_WIDTH, 32, byte-address width.
- CACHE_SIZE, 4096, total data bytes.
- LINE_SIZE, 16, bytes per line; 4 words.
- WAYS, 2, associativity; 2 only.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  CPU access valid this cycle.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_WIDTH  byte address, word-aligned.
- mem_w_data  in  DATA_WIDTH  write data.
- mem_r_data  out  DATA_WIDTH  hit word; 0 when no hit.
- cache_hit  out  1  lookup hit.
- fill_en  in  1  write fill_data into line word.
- fill_addr  in  ADDR_WIDTH  fill word address.
- fill_data  in  DATA_WIDTH  fill word.
- fill_mark_valid  in  1  last fill word; commit line.

## Operation
- Geometry: SETS = CACHE_SIZE/(LINE_SIZE*WAYS) = 128. Offset is addr[3:0], word select is addr[3:2], index is addr[10:4], tag is addr[31:11].
- Per set and way: valid bit, 21-bit tag, 4 data words. Per set: 1 replacement bit.
- Lookup is combinational: cache_hit = mem_valid & (valid & tag match in either way). mem_r_data is the selected word of the matching way, else 0. A lookup is performed for both reads and writes.
- Read hit: no state change, except the replacement update.
- Write hit: on the clock edge, the addressed word of the matching way takes mem_w_data (full word).
- Write miss: no cache change (no-write-allocate). RAM write-through is the MMU's job.
- Fill: the first fill_en while no fill is in progress does the following:
  - latches the victim way (invalid way 0, else invalid way 1, else the replacement-selected way);
  - clears that way's valid bit;
  - sets fill_active.
- Each fill_en writes fill_data to word fill_addr[3:2] of the latched victim at index fill_addr[10:4].
- fill_mark_valid (asserted together with the final fill_en) does the following:
  - writes the tag from fill_addr;
  - sets valid;
  - updates replacement;
  - clears fill_active.
- A CPU write hit and a fill to the same word in one cycle: the fill wins.

## Timing
- Hit latency is 0 cycles (combinational). Array updates take effect at the next posedge.
- A refill is 4 consecutive fill_en cycles, with fill_mark_valid on the 4th. The line reads as a hit from the cycle after commit.
- During a fill, the victim line misses.
- Reset: all valid bits 0, replacement bits 0, fill_active 0. Data and tag arrays are not reset.
- Output values during/after reset: cache_hit=0, mem_r_data=0.
- Reset mid-fill abandons the fill; the line stays invalid.

## Configuration
- L1_LRU_EN defined: the replacement bit is true LRU. It points to the way not touched by the latest read hit, write hit or fill commit.
- L1_LRU_EN undefined: round-robin. The replacement bit toggles only on fill commit; hits do not change it.

## Structure
- Shared package l1_cache_pkg holds the following:
  - localparams for SETS, OFFSET_BITS, INDEX_BITS, TAG_BITS and WORDS_PER_LINE;
  - a line_meta_t struct {valid, tag};
  - index/tag/word extraction functions.
- One sub-module, l1_cache_way: a single way's tag/valid/data arrays with a combinational read port and a registered word-write port. It is instantiated twice.
- The top contains hit/way select, victim latch, fill_active and replacement logic.
- The companion ram model is a separate block and is not part of this spec.

## Test plan
- Cold read: after reset, read 0x0000_0100 -> cache_hit=0, mem_r_data=0.
- Fill and commit:
  - stimulus: fill words 0x11,0x22,0x33,0x44 to 0x100..0x10C, mark_valid on the last;
  - next-cycle reads of 0x108 -> hit, 0x33;
  - read of 0x10C during the fill -> miss.
- Write hit then write miss:
  - write 0xDEAD_BEEF to 0x104 -> hit; a following read returns 0xDEAD_BEEF;
  - write to 0x0000_0900 (same index, different tag, not resident) -> miss; a subsequent read still misses.
- Two ways and eviction:
  - fill tags for 0x100, 0x900 and 0x1100 (all index 0x10);
  - with L1_LRU_EN, read 0x100 between the 2nd and 3rd fills: 0x100 stays resident and 0x900 misses;
  - without L1_LRU_EN: 0x100 is evicted.
- Reset mid-fill: assert rst after 2 fill words to 0x200, then read 0x200 -> miss; a fresh 4-word fill then hits.
- Fill/write collision: a fill word and a CPU write hit to the same word in one cycle -> the fill data is stored.
